// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: default widths, opcode
// values of the 9-bit processor and the feeder FSM state encoding.
package instr_feeder_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 16;

  // Opcode field is the top three bits of an IIIXXXYYY word.
  typedef enum logic [2:0] {
    OPC_MV   = 3'b000,
    OPC_MVI  = 3'b001,
    OPC_ADD  = 3'b010,
    OPC_SUB  = 3'b011,
    OPC_HALT = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_FETCH_IMM,
    S_LATCH_IMM,
    S_ISSUE,
    S_IMM_OUT,
    S_WAIT,
    S_HALT
  } state_e;

endpackage

// File: rtl/instr_feeder_if.sv
// Bus between the feeder, its instruction ROM and the processor:
// ROM address/data plus the DIN/Run/Done issue handshake.
interface instr_feeder_if
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;

  // Feeder side: drives the ROM address and the processor inputs.
  modport master (
    output mem_addr,
    output DIN,
    output Run,
    input  mem_q,
    input  Done
  );

  // ROM/processor side.
  modport slave (
    input  mem_addr,
    input  DIN,
    input  Run,
    output mem_q,
    output Done
  );

endinterface

// File: rtl/feeder_watchdog.sv
// Run-to-Done watchdog: clearable, enableable up-counter whose terminal
// output fires on the enabled cycle in which the count reaches TIMEOUT-1.
module feeder_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Terminal count: this increment brings the count to TIMEOUT-1.
  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 2));

  // Counter: clear has priority over counting.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/instr_feeder.sv
// Handshaked instruction source for the 9-bit processor. Fetches from a
// 1-cycle-latency ROM, issues one instruction per Run pulse (plus the
// immediate word for mvi), waits for Done, halts on HALT or watchdog trip.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  instr_feeder_if.master    bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              timeout
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] din_q;
  logic              run_q;
  logic              halted_q;
  logic              timeout_q;
  logic              done_seen_q;  // Done arrived in ISSUE of an mvi

  logic              wd_tc;
  logic [2:0]        rom_opc;
  logic [2:0]        instr_opc;
  state_e            after_done;

  assign rom_opc    = bus.mem_q[DATA_W-1 -: 3];
  assign instr_opc  = instr_q[DATA_W-1 -: 3];
  // Instruction boundary: keep going while enabled, otherwise park in IDLE.
  assign after_done = Enable ? S_FETCH : S_IDLE;

  assign bus.mem_addr = pc_q;
  assign bus.DIN      = din_q;
  assign bus.Run      = run_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign timeout      = timeout_q;

  feeder_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr_i  (state_q == S_ISSUE),
    .en_i   (state_q == S_WAIT),
    .tc_o   (wd_tc)
  );

  // Fetch/issue FSM with registered DIN, Run, halted and timeout.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      imm_q       <= '0;
      din_q       <= '0;
      run_q       <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      // NOTE: default first, so Run is a single-cycle pulse unless a branch re-arms it.
      run_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Enable) state_q <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          instr_q <= bus.mem_q;
          if (rom_opc == OPC_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_q + ADDR_W'(1);
            if (rom_opc == OPC_MVI) begin
              state_q <= S_FETCH_IMM;
            end else begin
              state_q <= S_ISSUE;
              din_q   <= bus.mem_q;
              run_q   <= 1'b1;
            end
          end
        end
        S_FETCH_IMM: begin
          state_q <= S_LATCH_IMM;
        end
        S_LATCH_IMM: begin
          imm_q   <= bus.mem_q;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= S_ISSUE;
          din_q   <= instr_q;
          run_q   <= 1'b1;
        end
        S_ISSUE: begin
          if (instr_opc == OPC_MVI) begin
            // The immediate is always presented, even if Done came early.
            state_q     <= S_IMM_OUT;
            din_q       <= imm_q;
            done_seen_q <= bus.Done;
          end else if (bus.Done) begin
            state_q <= after_done;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_IMM_OUT: begin
          done_seen_q <= 1'b0;
          if (bus.Done || done_seen_q) state_q <= after_done;
          else                         state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.Done) begin
            state_q <= after_done;
          end else if (wd_tc) begin
            state_q   <= S_HALT;
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: directed handshake/halt/timeout/enable/wrap/reset
// steps, then a random program checked against a transaction-level model.
module tb_instr_feeder;
  import instr_feeder_pkg::*;

  localparam int AW = 5;
  localparam int DW = 9;
  localparam int TO = 16;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] pc;
  logic          halted;
  logic          timeout;

  instr_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_feeder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clock   (clk),
    .Resetn  (rst_n),
    .Enable  (enable),
    .bus     (bus),
    .pc      (pc),
    .halted  (halted),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port ROM, one cycle read latency.
  logic [DW-1:0] rom [0:31];
  always @(posedge clk) bus.mem_q <= rom[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Processor model: answers each Run with a one-cycle Done done_delay cycles later.
  int done_delay = 0;
  bit respond_en = 1'b1;
  initial begin
    bus.Done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Run === 1'b1 && respond_en) begin
        repeat (done_delay) @(negedge clk);
        bus.Done = 1'b1;
        @(negedge clk);
        bus.Done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_run(input int max_cyc, output int n);
    n = 0;
    while (bus.Run !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 32; i++) rom[i] = 9'o700;
  endtask

  initial begin
    int            n;
    bit            run_seen;
    int            mpc;
    int            base;
    int            t;
    int            d;
    int            e_lat;
    bit            is_mvi;
    logic [DW-1:0] e_instr;
    logic [DW-1:0] e_imm;

    fill_halt();
    repeat (2) tick();
    check("rst_pc",      32'(pc),           0);
    check("rst_addr",    32'(bus.mem_addr), 0);
    check("rst_din",     32'(bus.DIN),      0);
    check("rst_run",     32'(bus.Run),      0);
    check("rst_halted",  32'(halted),       0);
    check("rst_timeout", 32'(timeout),      0);
    rst_n = 1'b1;
    tick();

    // Plain instruction, Done two cycles after Run, then HALT.
    rom[0] = 9'o012;
    rom[1] = 9'o700;
    done_delay = 2;
    enable = 1'b1;
    tick();
    check("t1_fetch_addr", 32'(bus.mem_addr), 0);
    check("t1_fetch_run",  32'(bus.Run),      0);
    wait_run(10, n);
    check("t1_run_lat", n, 2);
    check("t1_din",     32'(bus.DIN), 'o012);
    check("t1_pc",      32'(pc),      1);
    tick();
    check("t1_run_1cyc",  32'(bus.Run), 0);
    check("t1_din_hold",  32'(bus.DIN), 'o012);
    run_seen = 1'b0;
    repeat (2) begin
      tick();
      if (bus.Run === 1'b1) run_seen = 1'b1;
    end
    check("t1_no_rerun",   32'(run_seen),     0);
    check("t1_next_addr",  32'(bus.mem_addr), 1);
    repeat (2) tick();
    check("t1_halted",  32'(halted), 1);
    check("t1_halt_pc", 32'(pc),     1);

    // mvi with immediate, then HALT at address 2.
    apply_reset();
    fill_halt();
    rom[0] = 9'o100;
    rom[1] = 9'd5;
    done_delay = 3;
    enable = 1'b1;
    wait_run(20, n);
    check("t2_run_lat", n, 5);
    check("t2_din",     32'(bus.DIN), 'o100);
    check("t2_pc",      32'(pc),      2);
    tick();
    check("t2_imm",     32'(bus.DIN), 5);
    check("t2_imm_run", 32'(bus.Run), 0);
    repeat (3) tick();
    check("t2_fetch_addr", 32'(bus.mem_addr), 2);
    repeat (2) tick();
    check("t3_halted",  32'(halted),  1);
    check("t3_pc",      32'(pc),      2);
    check("t3_timeout", 32'(timeout), 0);
    run_seen = 1'b0;
    repeat (50) begin
      tick();
      if (bus.Run === 1'b1) run_seen = 1'b1;
    end
    check("t3_no_run",     32'(run_seen), 0);
    check("t3_halt_stays", 32'(halted),   1);
    rst_n = 1'b0;
    #1;
    check("t3_rst_pc",     32'(pc),     0);
    check("t3_rst_halted", 32'(halted), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Watchdog: Done never arrives.
    apply_reset();
    fill_halt();
    rom[0] = 9'o012;
    respond_en = 1'b0;
    enable = 1'b1;
    wait_run(10, n);
    check("t4_run", 32'(bus.Run), 1);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("t4_timeout_lat", n, TO);
    check("t4_halted",      32'(halted),  1);
    check("t4_run_low",     32'(bus.Run), 0);
    respond_en = 1'b1;

    // Enable dropped while the immediate is on DIN.
    apply_reset();
    fill_halt();
    rom[0] = 9'o100;
    rom[1] = 9'd77;
    rom[2] = 9'o013;
    done_delay = 3;
    enable = 1'b1;
    wait_run(20, n);
    check("t5_din", 32'(bus.DIN), 'o100);
    tick();
    enable = 1'b0;
    check("t5_imm",     32'(bus.DIN), 77);
    check("t5_imm_run", 32'(bus.Run), 0);
    run_seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.Run === 1'b1) run_seen = 1'b1;
    end
    check("t5_idle_no_run", 32'(run_seen), 0);
    check("t5_idle_pc",     32'(pc),       2);
    enable = 1'b1;
    wait_run(10, n);
    check("t5_resume_lat", n, 3);
    check("t5_resume_din", 32'(bus.DIN), 'o013);
    check("t5_resume_pc",  32'(pc),      3);

    // Walk pc to 31, mvi there takes its immediate from address 0; reset in WAIT.
    apply_reset();
    rom[0] = 9'o023;
    for (int i = 1; i < 31; i++) rom[i] = 9'o012;
    rom[31] = 9'o100;
    done_delay = 0;
    enable = 1'b1;
    for (int i = 0; i < 31; i++) begin
      wait_run(10, n);
      check("t6_walk_din", 32'(bus.DIN), 32'(rom[i]));
      check("t6_walk_pc",  32'(pc),      i + 1);
      tick();
    end
    done_delay = 10;
    wait_run(20, n);
    check("t6_wrap_din", 32'(bus.DIN), 'o100);
    check("t6_wrap_pc",  32'(pc),      1);
    tick();
    check("t6_wrap_imm", 32'(bus.DIN), 'o023);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pc",      32'(pc),           0);
    check("t6_rst_addr",    32'(bus.mem_addr), 0);
    check("t6_rst_din",     32'(bus.DIN),      0);
    check("t6_rst_run",     32'(bus.Run),      0);
    check("t6_rst_halted",  32'(halted),       0);
    check("t6_rst_timeout", 32'(timeout),      0);
    enable = 1'b0;
    repeat (15) tick();
    rst_n = 1'b1;
    tick();

    // Random program (no HALT opcodes) with random Done delays.
    for (int i = 0; i < 32; i++) rom[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
    mpc = 0;
    enable = 1'b1;
    base = cyc;
    for (int k = 0; k < 40; k++) begin
      e_instr = rom[mpc];
      is_mvi  = (e_instr[8:6] == OPC_MVI);
      e_lat   = is_mvi ? 5 : 3;
      mpc     = (mpc + 1) % 32;
      e_imm   = '0;
      if (is_mvi) begin
        e_imm = rom[mpc];
        mpc   = (mpc + 1) % 32;
      end
      d = int'($urandom_range(0, 6));
      done_delay = d;
      wait_run(30, n);
      check("rnd_run_cycle", cyc,               base + e_lat);
      check("rnd_din",       32'(bus.DIN),      32'(e_instr));
      check("rnd_pc",        32'(pc),           mpc);
      check("rnd_halted",    32'(halted),       0);
      t = cyc;
      tick();
      check("rnd_run_1cyc",  32'(bus.Run),      0);
      if (is_mvi) check("rnd_imm", 32'(bus.DIN), 32'(e_imm));
      // Instruction completes when Done is seen, but an mvi never before its immediate cycle.
      base = t + d;
      if (is_mvi && base < t + 1) base = t + 1;
    end
    check("rnd_timeout", 32'(timeout), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
